// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types and constants for the 5-stage pipeline.
//   pipe_state_t  : hazard-unit command for a pipeline latch
//   fetch_state_t : fetch-stage FSM state
//   PC_*          : PC source select encodings
//   NOP_INSTR     : instruction word used for bubbles and flushes
//   fetch_entry_t : {instr, pcplus4} pair moved between imem, buffer and latch
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      STALL  = 2'b01,
      FLUSH  = 2'b10
   } pipe_state_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      BUFFERED = 2'b01,
      HALTED   = 2'b10
   } fetch_state_t;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_J   = 2'b10;
   localparam logic [1:0] PC_JR  = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcplus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
//   One-entry holding register for an instruction that imem returned while
//   decode was stalled, so it can be handed over later without a refetch.
//   clear has priority over load.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   clear      in   empty the buffer
//   load       in   capture entry_in and mark full
//   entry_in   in   {instr, pcplus4} to capture
//   entry      out  stored {instr, pcplus4}
//   full       out  buffer holds an entry
// ----------------------------------------------------------------------------
module fetch_buffer
   import cpu_types_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  fetch_entry_t entry_in,
   output fetch_entry_t entry,
   output logic         full
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entry <= '0;
         full  <= 1'b0;
      end else if (clear) begin
         full  <= 1'b0;
      end else if (load) begin
         entry <= entry_in;
         full  <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: owns the PC, issues imem reads, and loads the
//   fetch/decode latch under hazard-unit control (FLUSH > STALL > NORMAL).
//   A one-entry fetch_buffer keeps an instruction returned during a stall.
//   Optional feature macro: FETCH_PERF_EN adds fetch/stall counters; when it
//   is undefined the counter outputs are tied to zero.
// Parameters
//   PC_INIT      PC value after reset
// Ports
//   CLK, nRST    clock (rising edge), synchronous active-low reset
//   PC_WEN       hazard unit allows a PC update this cycle
//   PCSrc        PC source: PC_SEQ / PC_BR / PC_J / PC_JR
//   branch_tgt, jump_tgt, jr_tgt   redirect targets
//   fd_state     hazard command for the F/D latch
//   halt         HALT decoded; stop fetching
//   ihit, imemload                 imem response for imemaddr
//   imemREN, imemaddr              imem request
//   fd_instr, fd_pcplus4, fd_valid F/D latch contents
//   fetch_cnt, stall_cnt           performance counters
// ----------------------------------------------------------------------------
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        PC_WEN,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] branch_tgt,
   input  logic [31:0] jump_tgt,
   input  logic [31:0] jr_tgt,
   input  pipe_state_t fd_state,
   input  logic        halt,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] fd_instr,
   output logic [31:0] fd_pcplus4,
   output logic        fd_valid,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   fetch_state_t state, state_next;
   logic [31:0]  pc, pc_next, pc_plus4, target;
   logic [31:0]  instr_next, pcplus4_next;
   logic         valid_next;
   logic         redirect, go_halt, in_run, in_halt, is_normal, drain;
   logic         buf_load, buf_clear, buf_full;
   fetch_entry_t buf_entry;

   assign in_run    = (state == RUN);
   assign in_halt   = (state == HALTED);
   assign is_normal = (fd_state != STALL) && (fd_state != FLUSH);
   assign redirect  = PC_WEN && (PCSrc != PC_SEQ);
   // Halt is ignored while decode is stalled; the stalled HALT re-presents.
   assign go_halt   = !in_halt && halt && (fd_state != STALL);
   assign drain     = (state == BUFFERED) && buf_full && is_normal;

   assign imemREN   = in_run;
   assign imemaddr  = pc;
   assign pc_plus4  = pc + 32'd4;

   always_comb begin
      case (PCSrc)
         PC_BR:   target = branch_tgt;
         PC_J:    target = jump_tgt;
         PC_JR:   target = jr_tgt;
         default: target = pc_plus4;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_next   = state;
      pc_next      = pc;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      instr_next   = fd_instr;
      pcplus4_next = fd_pcplus4;
      valid_next   = fd_valid;

      if (fd_state == FLUSH) begin
         instr_next = NOP_INSTR;
         valid_next = 1'b0;
      end else if (is_normal) begin
         if (drain) begin
            instr_next   = buf_entry.instr;
            pcplus4_next = buf_entry.pcplus4;
            valid_next   = 1'b1;
         end else if (in_run && ihit) begin
            instr_next   = imemload;
            pcplus4_next = pc_plus4;
            valid_next   = 1'b1;
         end else begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
         end
      end

      if (!in_halt) begin
         // The buffer only survives a plain STALL; anything else empties it.
         if (redirect || fd_state != STALL) begin
            buf_clear = 1'b1;
         end else if (in_run && ihit) begin
            buf_load = 1'b1;
         end

         if (go_halt) begin
            state_next = HALTED;
         end else begin
            if (redirect) begin
               pc_next = target;
            end else if (PC_WEN && in_run && ihit) begin
               pc_next = pc_plus4;
            end

            if (redirect) begin
               state_next = RUN;
            end else if (buf_load) begin
               state_next = BUFFERED;
            end else if (state == BUFFERED && fd_state != STALL) begin
               state_next = RUN;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: registered state uses non-blocking assignments so all flops
      // sample values from before the edge, independent of statement order.
      if (!nRST) begin
         state      <= RUN;
         pc         <= PC_INIT;
         fd_instr   <= NOP_INSTR;
         fd_pcplus4 <= 32'h0;
         fd_valid   <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         fd_instr   <= instr_next;
         fd_pcplus4 <= pcplus4_next;
         fd_valid   <= valid_next;
      end
   end

   fetch_buffer u_fetch_buffer (
      .clk      (CLK),
      .rst_n    (nRST),
      .clear    (buf_clear),
      .load     (buf_load),
      .entry_in ('{instr: imemload, pcplus4: pc_plus4}),
      .entry    (buf_entry),
      .full     (buf_full)
   );

`ifdef FETCH_PERF_EN
   logic fetch_evt;

   // A valid latch load is either an imem hit or a buffer drain under NORMAL.
   assign fetch_evt = is_normal && (drain || (in_run && ihit));

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         fetch_cnt <= 32'h0;
         stall_cnt <= 32'h0;
      end else begin
         if (fetch_evt)          fetch_cnt <= fetch_cnt + 32'd1;
         if (fd_state == STALL)  stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   assign fetch_cnt = 32'h0;
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage: a directed vector table, hand-written
//   halt / reset / counter sequences, and a randomized phase compared against
//   a queue-based reference model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
   import cpu_types_pkg::*;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        PC_WEN, halt, ihit;
   logic [1:0]  PCSrc;
   logic [31:0] branch_tgt, jump_tgt, jr_tgt, imemload;
   pipe_state_t fd_state;
   logic        imemREN, fd_valid;
   logic [31:0] imemaddr, fd_instr, fd_pcplus4, fetch_cnt, stall_cnt;

   fetch_stage #(.PC_INIT(PC_INIT)) dut (
      .CLK(CLK), .nRST(nRST), .PC_WEN(PC_WEN), .PCSrc(PCSrc),
      .branch_tgt(branch_tgt), .jump_tgt(jump_tgt), .jr_tgt(jr_tgt),
      .fd_state(fd_state), .halt(halt), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr), .fd_instr(fd_instr),
      .fd_pcplus4(fd_pcplus4), .fd_valid(fd_valid),
      .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives all inputs; the unselected targets carry distinct junk values.
   task automatic set_in(input pipe_state_t fs, input logic wen, input logic [1:0] src,
                         input logic hit, input logic h, input logic [31:0] load,
                         input logic [31:0] tgt);
      fd_state   = fs;
      PC_WEN     = wen;
      PCSrc      = src;
      ihit       = hit;
      halt       = h;
      imemload   = load;
      branch_tgt = (src == 2'b01) ? tgt : 32'hBAD0_0010;
      jump_tgt   = (src == 2'b10) ? tgt : 32'hBAD0_0020;
      jr_tgt     = (src == 2'b11) ? tgt : 32'hBAD0_0030;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      set_in(NORMAL, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      nRST = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      pipe_state_t fs;
      logic        wen;
      logic [1:0]  src;
      logic        hit;
      logic [31:0] load;
      logic [31:0] tgt;
      logic [31:0] e_addr;   // before the edge
      logic        e_ren;    // before the edge
      logic [31:0] e_instr;  // after the edge
      logic [31:0] e_p4;
      logic        e_valid;
   } vec_t;

   vec_t tbl[13];

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] instr; logic [31:0] p4; } ent_t;
   ent_t        m_buf[$];
   logic [31:0] m_pc, m_instr, m_p4, m_fcnt, m_scnt;
   logic        m_valid, m_halted;

   task automatic model_step();
      logic        buffered, redirect, go_halt;
      logic [31:0] tgt;
      if (!nRST) begin
         m_pc = PC_INIT; m_instr = 0; m_p4 = 0; m_valid = 0;
         m_buf.delete(); m_halted = 0; m_fcnt = 0; m_scnt = 0;
         return;
      end
      buffered = (m_buf.size() != 0);
      redirect = PC_WEN && (PCSrc != 2'b00);
      tgt = (PCSrc == 2'b01) ? branch_tgt : (PCSrc == 2'b10) ? jump_tgt : jr_tgt;
      if (fd_state == STALL) m_scnt = m_scnt + 1;

      if (fd_state == FLUSH) begin
         m_instr = 0; m_valid = 0;
      end else if (fd_state == NORMAL) begin
         if (!m_halted && buffered) begin
            m_instr = m_buf[0].instr; m_p4 = m_buf[0].p4; m_valid = 1; m_fcnt = m_fcnt + 1;
         end else if (!m_halted && ihit) begin
            m_instr = imemload; m_p4 = m_pc + 4; m_valid = 1; m_fcnt = m_fcnt + 1;
         end else begin
            m_instr = 0; m_valid = 0;
         end
      end

      if (!m_halted) begin
         go_halt = halt && (fd_state != STALL);
         if (redirect || fd_state != STALL) m_buf.delete();
         else if (!buffered && ihit) m_buf.push_back('{imemload, m_pc + 4});
         if (!go_halt) begin
            if (redirect) m_pc = tgt;
            else if (PC_WEN && !buffered && ihit) m_pc = m_pc + 4;
         end
         m_halted = go_halt;
      end
   endtask

   initial begin
      tbl[0]  = '{NORMAL, 1'b1, 2'b00, 1'b1, 32'h11,   32'h0,   32'h0,   1'b1, 32'h11,   32'h4,   1'b1};
      tbl[1]  = '{NORMAL, 1'b1, 2'b00, 1'b1, 32'h22,   32'h0,   32'h4,   1'b1, 32'h22,   32'h8,   1'b1};
      tbl[2]  = '{STALL,  1'b1, 2'b00, 1'b1, 32'hAAAA, 32'h0,   32'h8,   1'b1, 32'h22,   32'h8,   1'b1};
      tbl[3]  = '{NORMAL, 1'b1, 2'b00, 1'b0, 32'h0,    32'h0,   32'hC,   1'b0, 32'hAAAA, 32'hC,   1'b1};
      tbl[4]  = '{NORMAL, 1'b1, 2'b00, 1'b1, 32'h33,   32'h0,   32'hC,   1'b1, 32'h33,   32'h10,  1'b1};
      tbl[5]  = '{NORMAL, 1'b1, 2'b10, 1'b1, 32'h44,   32'h40,  32'h10,  1'b1, 32'h44,   32'h14,  1'b1};
      tbl[6]  = '{FLUSH,  1'b1, 2'b01, 1'b1, 32'h55,   32'h100, 32'h40,  1'b1, 32'h0,    32'h14,  1'b0};
      tbl[7]  = '{NORMAL, 1'b1, 2'b00, 1'b0, 32'h0,    32'h0,   32'h100, 1'b1, 32'h0,    32'h14,  1'b0};
      tbl[8]  = '{STALL,  1'b0, 2'b00, 1'b1, 32'hB0,   32'h0,   32'h100, 1'b1, 32'h0,    32'h14,  1'b0};
      tbl[9]  = '{STALL,  1'b1, 2'b11, 1'b0, 32'h0,    32'h200, 32'h100, 1'b0, 32'h0,    32'h14,  1'b0};
      tbl[10] = '{NORMAL, 1'b1, 2'b00, 1'b1, 32'hC0,   32'h0,   32'h200, 1'b1, 32'hC0,   32'h204, 1'b1};
      tbl[11] = '{NORMAL, 1'b1, 2'b10, 1'b1, 32'hC4,   32'hFFFF_FFFC, 32'h204, 1'b1, 32'hC4, 32'h208, 1'b1};
      tbl[12] = '{NORMAL, 1'b1, 2'b00, 1'b1, 32'hC8,   32'h0,   32'hFFFF_FFFC, 1'b1, 32'hC8, 32'h0, 1'b1};

      // Reset state
      do_reset();
      check("reset imemaddr", imemaddr, PC_INIT);
      check("reset imemREN", {31'b0, imemREN}, 32'd1);
      check("reset fd_instr", fd_instr, 32'h0);
      check("reset fd_pcplus4", fd_pcplus4, 32'h0);
      check("reset fd_valid", {31'b0, fd_valid}, 32'd0);
      check("reset fetch_cnt", fetch_cnt, 32'h0);
      check("reset stall_cnt", stall_cnt, 32'h0);

      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].fs, tbl[i].wen, tbl[i].src, tbl[i].hit, 1'b0, tbl[i].load, tbl[i].tgt);
         @(negedge CLK);
         check($sformatf("vec%0d imemaddr", i), imemaddr, tbl[i].e_addr);
         check($sformatf("vec%0d imemREN", i), {31'b0, imemREN}, {31'b0, tbl[i].e_ren});
         tick();
         check($sformatf("vec%0d fd_instr", i), fd_instr, tbl[i].e_instr);
         check($sformatf("vec%0d fd_pcplus4", i), fd_pcplus4, tbl[i].e_p4);
         check($sformatf("vec%0d fd_valid", i), {31'b0, fd_valid}, {31'b0, tbl[i].e_valid});
      end

      // Halt: pc frozen at 4, imem idle, redirects ignored, bubbles delivered
      set_in(NORMAL, 1'b1, 2'b00, 1'b1, 1'b0, 32'hCC, 32'h0);
      tick();
      check("pre-halt imemaddr", imemaddr, 32'h4);
      set_in(NORMAL, 1'b1, 2'b01, 1'b1, 1'b1, 32'hD0, 32'h500);
      tick();
      check("halt imemREN", {31'b0, imemREN}, 32'd0);
      check("halt+redirect pc", imemaddr, 32'h4);
      for (int i = 0; i < 3; i++) begin
         set_in(NORMAL, 1'b1, 2'b01, 1'b1, 1'b0, 32'hE0, 32'h300);
         tick();
         check($sformatf("halted%0d imemaddr", i), imemaddr, 32'h4);
         check($sformatf("halted%0d imemREN", i), {31'b0, imemREN}, 32'd0);
         check($sformatf("halted%0d fd_valid", i), {31'b0, fd_valid}, 32'd0);
      end
      do_reset();
      check("unhalt imemaddr", imemaddr, PC_INIT);
      check("unhalt imemREN", {31'b0, imemREN}, 32'd1);

      // Reset while an instruction sits in the buffer: it must not survive
      set_in(NORMAL, 1'b1, 2'b00, 1'b1, 1'b0, 32'h77, 32'h0);
      tick();
      set_in(STALL, 1'b1, 2'b00, 1'b1, 1'b0, 32'h88, 32'h0);
      tick();
      check("buffered imemREN", {31'b0, imemREN}, 32'd0);
      do_reset();
      check("rst-buf imemREN", {31'b0, imemREN}, 32'd1);
      check("rst-buf fd_valid", {31'b0, fd_valid}, 32'd0);
      set_in(NORMAL, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check("rst-buf no drain valid", {31'b0, fd_valid}, 32'd0);
      check("rst-buf no drain instr", fd_instr, 32'h0);

      // Counters: 5 fetches then 2 stall cycles
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_in(NORMAL, 1'b1, 2'b00, 1'b1, 1'b0, 32'h1000 + i, 32'h0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         set_in(STALL, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end
`ifdef FETCH_PERF_EN
      check("fetch_cnt", fetch_cnt, 32'd5);
      check("stall_cnt", stall_cnt, 32'd2);
`else
      check("fetch_cnt", fetch_cnt, 32'd0);
      check("stall_cnt", stall_cnt, 32'd0);
`endif

      // Randomized phase against the reference model
      do_reset();
      model_step();
      for (int i = 0; i < 800; i++) begin
         int unsigned r;
         nRST = ($urandom_range(0, 59) != 0);
         r = $urandom_range(0, 9);
         fd_state   = (r < 6) ? NORMAL : (r < 8) ? STALL : FLUSH;
         PC_WEN     = ($urandom_range(0, 3) != 0);
         PCSrc      = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
         ihit       = ($urandom_range(0, 3) != 0);
         halt       = ($urandom_range(0, 79) == 0);
         imemload   = $urandom;
         branch_tgt = $urandom;
         jump_tgt   = $urandom;
         jr_tgt     = $urandom;
         @(negedge CLK);
         check("rand imemaddr", imemaddr, m_pc);
         check("rand imemREN", {31'b0, imemREN}, {31'b0, !m_halted && m_buf.size() == 0});
         @(posedge CLK);
         model_step();
         #1;
         check("rand fd_instr", fd_instr, m_instr);
         check("rand fd_pcplus4", fd_pcplus4, m_p4);
         check("rand fd_valid", {31'b0, fd_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
         check("rand fetch_cnt", fetch_cnt, m_fcnt);
         check("rand stall_cnt", stall_cnt, m_scnt);
`else
         check("rand fetch_cnt", fetch_cnt, 32'd0);
         check("rand stall_cnt", stall_cnt, 32'd0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
